// File: rtl/bus_timer_if.sv
// Bus interface between an initiator and a single follower slot.
// Reads return data one cycle after read_req; writes take effect at the edge.
interface bus_timer_if;
    logic [31:0] addr;
    logic        read_req;
    logic        write_req;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_data_valid;

    modport follower (
        input  addr,
        input  read_req,
        input  write_req,
        input  byte_enable,
        input  write_data,
        output read_data,
        output read_data_valid
    );

    modport initiator (
        output addr,
        output read_req,
        output write_req,
        output byte_enable,
        output write_data,
        input  read_data,
        input  read_data_valid
    );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped prescaled up-counter with compare, sticky match and level irq.
// Register select is addr[4:2]; upper address bits are decoded upstream.
module bus_timer #(
    parameter int CountWidth    = 32,
    parameter int PrescaleWidth = 16
) (
    input  logic             clk,
    input  logic             reset,
    bus_timer_if.follower    bus,
    output logic             irq
);

    logic [2:0]               ctrl_q, ctrl_d;
    logic [PrescaleWidth-1:0] pre_q, pre_d;
    logic [PrescaleWidth-1:0] pcnt_q, pcnt_d;
    logic [CountWidth-1:0]    cmp_q, cmp_d;
    logic [CountWidth-1:0]    cnt_q, cnt_d;
    logic                     match_q, match_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     rvalid_q, rvalid_d;

    logic [2:0]  sel;
    logic [31:0] rd_val;
    logic [31:0] wr_val;
    logic        wr_any;
    logic        tick;
    logic        hit;
    logic        unused_addr;

    assign sel         = bus.addr[4:2];
    assign unused_addr = ^{bus.addr[31:5], bus.addr[1:0]};
    assign wr_any      = bus.write_req && (|bus.byte_enable);
    assign tick        = ctrl_q[0] && (pcnt_q == pre_q);
    assign hit         = tick && (cnt_q == cmp_q);

    always_comb begin
        rd_val = '0;
        case (sel)
            3'd0:    rd_val = 32'(ctrl_q);
            3'd1:    rd_val = 32'(pre_q);
            3'd2:    rd_val = 32'(cmp_q);
            3'd3:    rd_val = 32'(cnt_q);
            3'd4:    rd_val = 32'(match_q);
            default: rd_val = '0;
        endcase
    end

    // Disabled lanes keep the current register contents.
    always_comb begin
        wr_val = rd_val;
        for (int k = 0; k < 4; k++) begin
            if (bus.byte_enable[k]) begin
                wr_val[8*k +: 8] = bus.write_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        pre_d    = pre_q;
        pcnt_d   = pcnt_q;
        cmp_d    = cmp_q;
        cnt_d    = cnt_q;
        match_d  = match_q;
        rvalid_d = bus.read_req;
        rdata_d  = bus.read_req ? rd_val : '0;

        if (ctrl_q[0]) begin
            pcnt_d = tick ? '0 : pcnt_q + PrescaleWidth'(1);
        end
        if (tick) begin
            cnt_d = (hit && ctrl_q[1]) ? '0 : cnt_q + CountWidth'(1);
        end

        if (wr_any) begin
            case (sel)
                3'd0: begin
                    ctrl_d = wr_val[2:0];
                    if (!ctrl_q[0] && wr_val[0]) begin
                        pcnt_d = '0;
                    end
                end
                3'd1: pre_d = wr_val[PrescaleWidth-1:0];
                3'd2: cmp_d = wr_val[CountWidth-1:0];
                3'd3: cnt_d = wr_val[CountWidth-1:0];
                3'd4: begin
                    if (bus.byte_enable[0] && bus.write_data[0]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A new match overrides a same-cycle clear.
        if (hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            pre_q    <= '0;
            pcnt_q   <= '0;
            cmp_q    <= '0;
            cnt_q    <= '0;
            match_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            pre_q    <= pre_d;
            pcnt_q   <= pcnt_d;
            cmp_q    <= cmp_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.read_data       = rdata_q;
    assign bus.read_data_valid = rvalid_q;
    assign irq                 = match_q & ctrl_q[2];

endmodule

// File: tb/tb_bus_timer.sv
// Randomized and directed checks of bus_timer against a register-level model.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_bus_timer;

    logic clk;
    logic reset;
    logic irq;

    bus_timer_if bus ();

    bus_timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    logic [2:0]  m_ctrl;
    logic [15:0] m_pre;
    logic [15:0] m_pc;
    logic [31:0] m_cmp;
    logic [31:0] m_cnt;
    logic        m_match;
    logic [31:0] m_rdata;
    logic        m_rvalid;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [2:0] s);
        case (s)
            3'd0:    return {29'b0, m_ctrl};
            3'd1:    return {16'b0, m_pre};
            3'd2:    return m_cmp;
            3'd3:    return m_cnt;
            3'd4:    return {31'b0, m_match};
            default: return 32'b0;
        endcase
    endfunction

    task automatic m_reset();
        m_ctrl   = '0;
        m_pre    = '0;
        m_pc     = '0;
        m_cmp    = '0;
        m_cnt    = '0;
        m_match  = 1'b0;
        m_rdata  = '0;
        m_rvalid = 1'b0;
    endtask

    // One clock edge of the timer as described at register level.
    task automatic m_step(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
        logic [2:0]  s;
        logic [31:0] v;
        logic        en;
        logic        tk;
        logic        hit;
        s   = a[4:2];
        en  = m_ctrl[0];
        tk  = en && (m_pc == m_pre);
        hit = tk && (m_cnt == m_cmp);
        v   = m_reg(s);
        for (int k = 0; k < 4; k++)
            if (be[k]) v[8*k +: 8] = wd[8*k +: 8];
        m_rvalid = rd;
        m_rdata  = rd ? m_reg(s) : 32'b0;
        if (en) m_pc = tk ? 16'd0 : m_pc + 16'd1;
        if (tk) m_cnt = (hit && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
        if (wr && be != 4'b0) begin
            case (s)
                3'd0: begin
                    if (!en && v[0]) m_pc = 16'd0;
                    m_ctrl = v[2:0];
                end
                3'd1: m_pre = v[15:0];
                3'd2: m_cmp = v;
                3'd3: m_cnt = v;
                3'd4: if (be[0] && wd[0]) m_match = 1'b0;
                default: ;
            endcase
        end
        if (hit) m_match = 1'b1;
    endtask

    task automatic cycle(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
        bus.read_req    = rd;
        bus.write_req   = wr;
        bus.addr        = a;
        bus.byte_enable = be;
        bus.write_data  = wd;
        @(posedge clk);
        m_step(rd, wr, a, be, wd);
        #1;
        chk("rvalid", {31'b0, bus.read_data_valid}, {31'b0, m_rvalid});
        chk("rdata", bus.read_data, m_rdata);
        chk("irq", {31'b0, irq}, {31'b0, m_match & m_ctrl[2]});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, 4'hF, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic rd_exp(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        cycle(1'b1, 1'b0, a, 4'h0, 32'h0);
        chk({tag, "_v"}, {31'b0, bus.read_data_valid}, 32'd1);
        chk(tag, bus.read_data, exp);
    endtask

    initial begin
        logic        r;
        logic        w;
        logic [2:0]  s;
        logic [3:0]  be;
        logic [31:0] a;
        logic [31:0] d;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.read_req    = 1'b0;
        bus.write_req   = 1'b0;
        bus.addr        = '0;
        bus.byte_enable = '0;
        bus.write_data  = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", {31'b0, bus.read_data_valid}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);

        // Read issued in the cycle reset is released.
        @(negedge clk);
        reset = 1'b0;
        rd_exp("rst_count", 32'h0C, 32'h0);
        chk("rst_irq2", {31'b0, irq}, 32'd0);

        // Prescale 3, compare 2, auto-reload with irq.
        wr(32'h04, 32'd3);
        wr(32'h08, 32'd2);
        wr(32'h00, 32'h7);
        idle(11);
        chk("irq_before", {31'b0, irq}, 32'd0);
        idle(1);
        chk("irq_rise", {31'b0, irq}, 32'd1);
        rd_exp("reload_cnt", 32'h0C, 32'd0);
        wr(32'h10, 32'h1);
        chk("irq_w1c", {31'b0, irq}, 32'd0);

        // Partial byte-lane write.
        wr(32'h00, 32'h0);
        wr(32'h0C, 32'h0);
        cycle(1'b0, 1'b1, 32'h0C, 4'b0101, 32'h12345678);
        rd_exp("be_count", 32'h0C, 32'h00340078);

        // Wrap at 2^32 with compare 0 and no auto-reload.
        wr(32'h04, 32'd0);
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'hFFFF_FFFE);
        wr(32'h00, 32'h1);
        idle(3);
        rd_exp("wrap_cnt", 32'h0C, 32'd1);
        rd_exp("wrap_match", 32'h10, 32'd1);
        wr(32'h00, 32'h0);

        // Read and write to the same register in one cycle.
        wr(32'h08, 32'd5);
        cycle(1'b1, 1'b1, 32'h08, 4'hF, 32'd9);
        chk("rw_old", bus.read_data, 32'd5);
        rd_exp("rw_new", 32'h08, 32'd9);
        rd_exp("b2b_ctrl", 32'h00, 32'd0);
        rd_exp("b2b_pre", 32'h04, 32'd0);
        rd_exp("b2b_cmp", 32'h08, 32'd9);
        rd_exp("unmapped", 32'h1C, 32'd0);

        // Clear racing a fresh match.
        wr(32'h10, 32'h1);
        wr(32'h0C, 32'd7);
        wr(32'h08, 32'd7);
        wr(32'h00, 32'h1);
        wr(32'h10, 32'h1);
        rd_exp("race_match", 32'h10, 32'd1);

        // Asynchronous reset one cycle after a read.
        wr(32'h00, 32'h7);
        idle(3);
        cycle(1'b1, 1'b0, 32'h0C, 4'h0, 32'h0);
        bus.read_req = 1'b0;
        reset = 1'b1;
        m_reset();
        #1;
        chk("arst_rvalid", {31'b0, bus.read_data_valid}, 32'd0);
        chk("arst_rdata", bus.read_data, 32'd0);
        chk("arst_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++)
            rd_exp("arst_reg", 32'(i * 4), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 3) == 0);
            s  = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_FFE0) | {27'b0, s, 2'b00}
                 | ($urandom & 32'h3);
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (s)
                3'd0:    d = $urandom_range(0, 7);
                3'd1:    d = $urandom_range(0, 3);
                3'd2,
                3'd3:    d = ($urandom_range(0, 9) == 0) ? $urandom
                             : $urandom_range(0, 12);
                default: d = $urandom;
            endcase
            cycle(r, w, a, be, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped timer that acts as a responder (follower) on the system bus; an initiator such as a CPU or test sequencer drives it.
- Contains a programmable prescaler, an up-counter, a compare register, a sticky match flag and a level interrupt.
- Sits behind system_bus in one follower slot. system_bus decodes the upper address bits; this block decodes only addr[4:2].

Parameters:
- CountWidth, 32: width of the COUNT and COMPARE registers (1..32). Upper read bits are zero.
- PrescaleWidth, 16: width of the PRESCALE register and of the internal prescale counter (1..32).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- bus  follower modport of the bus interface  -  carries these signals:
  - addr  in  32
  - read_req  in  1
  - write_req  in  1
  - byte_enable  in  4
  - write_data  in  32
  - read_data  out  32
  - read_data_valid  out  1
- irq  output  1  level interrupt, equal to match & irq_enable.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: all registers 0; prescale counter 0; read_data 0; read_data_valid 0; irq 0.
- Register map, by addr[4:2]:
  - 0 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_enable.
  - 1 PRESCALE.
  - 2 COMPARE.
  - 3 COUNT.
  - 4 STATUS: bit0 match, write-1-to-clear.
  - 5..7 unmapped: reads return 0, writes are ignored.
- Writes:
  - Take effect at the clk edge where write_req=1.
  - Byte lane k is updated only if byte_enable[k]=1; lanes above the register width are dropped.
  - A write with byte_enable=0 has no effect.
- Reads:
  - read_req=1 in cycle N gives read_data_valid=1 and read_data in cycle N+1, for exactly one cycle.
  - read_data is 0 whenever read_data_valid=0.
  - Reads have no side effects.
  - Back-to-back reads give valid in consecutive cycles.
- read_req and write_req in the same cycle: both are accepted, and the read returns the pre-write value.
- No stalls: the block never back-pressures the bus.
- Prescaler:
  - While enable=1, the prescale counter increments every cycle.
  - When it equals PRESCALE, it returns to 0 and asserts tick for one cycle.
  - PRESCALE=0 produces a tick every cycle.
- Counter on tick:
  - If COUNT==COMPARE: set match. Then COUNT goes to 0 if auto_reload=1, otherwise to COUNT+1.
  - Otherwise: COUNT goes to COUNT+1, wrapping modulo 2^CountWidth.
- enable=0 freezes both the prescale counter and COUNT; no ticks occur.
- Clearing enable does not reset the prescale counter.
- Writing CTRL.enable 0->1 resets the prescale counter to 0.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick wins; the written value is loaded and there is no increment.
  - A match compare in that cycle still uses the pre-write COUNT.
  - A W1C of match in the same cycle as a new match leaves match=1 (set wins).
  - A write to PRESCALE takes effect from the next cycle's comparison; the prescale counter is not reset.
- irq is combinational from registered state, so it changes the cycle after match or irq_enable is updated.
- Reset asserted mid-operation:
  - Clears everything asynchronously.
  - A pending read_data_valid is dropped.
  - A read_req in the same cycle as reset deassertion is serviced normally.

Test Plan:
- Reset released, read addr 0x0C -> read_data_valid high one cycle later, read_data=0; irq=0.
- Write PRESCALE=3, COMPARE=2, CTRL=0x7 -> COUNT increments every 4 cycles; match is set and irq rises on the tick where COUNT==2, then COUNT=0. Write STATUS=1 -> irq=0.
- Write COUNT=0x12345678 with byte_enable=4'b0101 from 0 -> COUNT reads 0x00340078.
- CTRL=0x1, PRESCALE=0, COUNT=0xFFFFFFFE, COMPARE=0 -> COUNT goes FFFFFFFF, 0, 1; match set on the tick where COUNT was 0. Without auto_reload, COUNT continues to 1.
- Same-cycle read_req+write_req to COMPARE (old 5, new 9) -> read returns 5; a following read returns 9. Back-to-back reads of addrs 0x0,0x4,0x8 -> three consecutive valid cycles with the correct data.
- Reset asserted one cycle after read_req while counting -> read_data_valid=0, all registers 0 immediately; W1C racing a new match -> match stays 1.
